uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between C_REQ byte sources, e.g. the sigma-delta sample streamer, button/switch event reporter and status replies.
- Arbitration is round-robin per byte, or per frame when a requester holds a frame lock through multi-byte messages.
- Sits between the requesters and the uart_tx instance in top. Drives the transmitter's send/data inputs and watches its busy output.

Parameters:
- C_REQ, 3, number of requesters (2..4).
- C_DATA_WIDTH, 8, byte width; must match the transmitter's C_UART_DATA_WIDTH.
- C_LOCK_TMO, 1_000_000, cycles a locked frame may stall with no valid byte before the lock is forcibly released (10 ms at 100 MHz).
- C_START_TMO, 16, cycles allowed for txBusy to rise after txSend.

Ports:
- rstb  input  1  asynchronous reset, active low.
- clk  input  1  system clock.
- reqValid  input  C_REQ  per-requester byte available; held with data until the matching reqAck.
- reqLast  input  C_REQ  qualifies the offered byte: 1 = last byte of frame, 0 = more bytes follow.
- reqData  input  C_REQ*C_DATA_WIDTH  packed bytes; requester k occupies bits [k*W +: W].
- reqAck  output  C_REQ  one-cycle pulse; byte of requester k taken.
- txData  output  C_DATA_WIDTH  byte to transmitter, stable from txSend until next send.
- txSend  output  1  one-cycle send strobe to transmitter.
- txBusy  input  1  transmitter busy.
- grant  output  2  index of current/last granted requester.
- locked  output  1  a frame lock is held by grant.
- tmoErr  output  1  one-cycle pulse on any timeout.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: txData, txSend, reqAck, grant, locked, tmoErr. Round-robin pointer = C_REQ-1, so requester 0 has first priority.
- IDLE:
  - If txBusy=0 and any reqValid, choose k = first valid in order ptr+1, ptr+2, … mod C_REQ.
  - On that edge, register: txData<=reqData[k], txSend<=1, reqAck[k]<=1, grant<=k, ptr<=k, locked<=~reqLast[k]. Go to WAIT_BUSY.
  - Latency: valid seen at edge N produces txSend/reqAck high during cycle N+1, for exactly one cycle.
- WAIT_BUSY:
  - txBusy=1: go to WAIT_DONE.
  - C_START_TMO cycles without txBusy: pulse tmoErr, clear locked, go to IDLE.
- WAIT_DONE:
  - txBusy=0: go to LOCKED if locked=1, else IDLE.
- LOCKED:
  - Only requester grant is served; other reqValid are ignored.
  - reqValid[grant]=1 and txBusy=0: send exactly as in IDLE (same one-cycle strobes, locked<=~reqLast[grant]). ptr is unchanged.
  - Lock counter runs while reqValid[grant]=0 and clears on each send.
  - Counter reaching C_LOCK_TMO-1: pulse tmoErr, locked<=0, go to IDLE.
- reqValid and reqData are sampled only in IDLE/LOCKED. A requester may change them the cycle after its reqAck.
- Requests arriving during WAIT_BUSY/WAIT_DONE stay pending; no byte is lost or duplicated.
- Simultaneous requests: exactly one reqAck bit per send, never more.
- Each byte is acknowledged once, regardless of how long the requester holds valid.
- Reset mid-frame or mid-byte: lock and pending state are discarded immediately. The transmitter's own reset handles the line.
- Counter width: $clog2(C_LOCK_TMO) bits, saturating compare, no wrap.

Test Plan:
- Single byte: reqValid=001, reqData[0]=8'hA5, reqLast=1 -> next cycle txSend=1, txData=A5, reqAck=001 (1 cycle each). Arbiter returns to IDLE after txBusy falls. grant=0, locked=0.
- Fairness: all three valid continuously, reqLast=111 -> grant sequence 0,1,2,0,1,2. Exactly one reqAck per txSend. Six bytes out in order.
- Frame lock: req1 sends 3 bytes with reqLast 0,0,1 while req0 and req2 are valid -> bytes 1,1,1 go out contiguously with locked=1 through byte 2. locked falls after byte 3; next grant=2, then 0.
- Lock timeout (C_LOCK_TMO=100 in bench): req2 sends a byte with reqLast=0, then drops valid -> after 100 cycles tmoErr pulses once, locked=0. Pending req0 is served next.
- Start timeout: txBusy tied 0, one request -> txSend pulses once, and 16 cycles later tmoErr pulses. State returns to IDLE; the already-acked byte is not resent.
- Reset mid-frame: assert rstb=0 during LOCKED -> all outputs 0 asynchronously. After release, a request from req1 with req0 also valid is granted to req0 first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART transmitter between C_REQ byte sources. Arbitration is
//    round-robin per byte, or per frame while a requester holds a frame lock.
// Latency: reqValid sampled at edge N gives txSend/reqAck high for one cycle in N+1.
// Backpressure: a requester holds reqValid/reqData until its reqAck pulse; nothing
//    is sampled while the transmitter is starting or busy (WAIT_BUSY/WAIT_DONE).
//
// Ports:
//    rstb      async active-low reset
//    clk       system clock
//    reqValid  per-requester byte available
//    reqLast   per-requester last-byte-of-frame qualifier
//    reqData   packed bytes, requester k at [k*W +: W]
//    reqAck    one-cycle pulse, byte of requester k taken
//    txData    byte to transmitter, held from txSend until the next send
//    txSend    one-cycle send strobe
//    txBusy    transmitter busy
//    grant     index of current/last granted requester
//    locked    frame lock held by grant
//    tmoErr    one-cycle pulse on a start or lock timeout
module uart_tx_arbiter #(
   parameter int C_REQ        = 3,
   parameter int C_DATA_WIDTH = 8,
   parameter int C_LOCK_TMO   = 1_000_000,
   parameter int C_START_TMO  = 16
) (
   input  logic                          rstb,
   input  logic                          clk,
   input  logic [C_REQ-1:0]              reqValid,
   input  logic [C_REQ-1:0]              reqLast,
   input  logic [C_REQ*C_DATA_WIDTH-1:0] reqData,
   output logic [C_REQ-1:0]              reqAck,
   output logic [C_DATA_WIDTH-1:0]       txData,
   output logic                          txSend,
   input  logic                          txBusy,
   output logic [1:0]                    grant,
   output logic                          locked,
   output logic                          tmoErr
);

   localparam int C_LOCK_W  = (C_LOCK_TMO  > 1) ? $clog2(C_LOCK_TMO)  : 1;
   localparam int C_START_W = (C_START_TMO > 1) ? $clog2(C_START_TMO) : 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_LOCKED    = 2'd3
   } state_t;

   state_t                  state, stateNext;
   logic [1:0]              ptr, ptrNext;
   logic [1:0]              grantNext;
   logic                    lockedNext;
   logic [C_DATA_WIDTH-1:0] txDataNext;
   logic                    txSendNext;
   logic [C_REQ-1:0]        reqAckNext;
   logic                    tmoErrNext;
   logic [C_LOCK_W-1:0]     lockCnt, lockCntNext;
   logic [C_START_W-1:0]    startCnt, startCntNext;

   // Round-robin search: first valid requester in order ptr+1, ptr+2, ... mod C_REQ.
   // Bit tests use shifted masks so the index width never has to match C_REQ.
   logic [1:0] rrIdx;
   logic       rrHit;
   int         cand;

   always_comb begin
      rrIdx = ptr;
      rrHit = 1'b0;
      cand  = 0;
      for (int i = 1; i <= C_REQ; i++) begin
         cand = (int'(ptr) + i) % C_REQ;
         if (!rrHit && ((reqValid & (C_REQ'(1) << cand)) != '0)) begin
            rrHit = 1'b1;
            rrIdx = 2'(cand);
         end
      end
   end

   logic grantValid;
   assign grantValid = (reqValid & (C_REQ'(1) << grant)) != '0;

   logic                    doSend;
   logic [1:0]              selIdx;
   logic [C_DATA_WIDTH-1:0] selData;
   logic                    selLast;

   always_comb begin
      stateNext    = state;
      ptrNext      = ptr;
      grantNext    = grant;
      lockedNext   = locked;
      txDataNext   = txData;
      txSendNext   = 1'b0;
      reqAckNext   = '0;
      tmoErrNext   = 1'b0;
      lockCntNext  = lockCnt;
      startCntNext = startCnt;
      doSend       = 1'b0;
      selIdx       = grant;
      selData      = '0;
      selLast      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!txBusy && rrHit) begin
               doSend  = 1'b1;
               selIdx  = rrIdx;
               ptrNext = rrIdx;
            end
         end

         ST_WAIT_BUSY: begin
            if (txBusy) begin
               stateNext = ST_WAIT_DONE;
            end else if (startCnt >= C_START_W'(C_START_TMO - 1)) begin
               // Transmitter never started: the byte is already acked, so drop it.
               tmoErrNext = 1'b1;
               lockedNext = 1'b0;
               stateNext  = ST_IDLE;
            end else begin
               startCntNext = startCnt + C_START_W'(1);
            end
         end

         ST_WAIT_DONE: begin
            if (!txBusy) begin
               stateNext = locked ? ST_LOCKED : ST_IDLE;
            end
         end

         ST_LOCKED: begin
            // Only the lock holder is served; the stall counter runs only while
            // it has nothing to offer, never while the line is merely busy.
            if (grantValid) begin
               if (!txBusy) begin
                  doSend = 1'b1;
                  selIdx = grant;
               end
            end else if (lockCnt >= C_LOCK_W'(C_LOCK_TMO - 1)) begin
               tmoErrNext = 1'b1;
               lockedNext = 1'b0;
               stateNext  = ST_IDLE;
            end else begin
               lockCntNext = lockCnt + C_LOCK_W'(1);
            end
         end

         default: stateNext = ST_IDLE;
      endcase

      selData = C_DATA_WIDTH'(reqData >> (int'(selIdx) * C_DATA_WIDTH));
      selLast = (reqLast & (C_REQ'(1) << selIdx)) != '0;

      if (doSend) begin
         txDataNext   = selData;
         txSendNext   = 1'b1;
         reqAckNext   = C_REQ'(1) << selIdx;
         grantNext    = selIdx;
         lockedNext   = ~selLast;
         stateNext    = ST_WAIT_BUSY;
         startCntNext = '0;
         lockCntNext  = '0;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state    <= ST_IDLE;
         ptr      <= 2'(C_REQ - 1);
         grant    <= '0;
         locked   <= 1'b0;
         txData   <= '0;
         txSend   <= 1'b0;
         reqAck   <= '0;
         tmoErr   <= 1'b0;
         lockCnt  <= '0;
         startCnt <= '0;
      end else begin
         state    <= stateNext;
         ptr      <= ptrNext;
         grant    <= grantNext;
         locked   <= lockedNext;
         txData   <= txDataNext;
         txSend   <= txSendNext;
         reqAck   <= reqAckNext;
         tmoErr   <= tmoErrNext;
         lockCnt  <= lockCntNext;
         startCnt <= startCntNext;
      end
   end

endmodule
